// File: rtl/traffic_light_monitor_pkg.sv
// Shared types and helpers for the traffic light monitor: phase encoding,
// default phase durations and light-vector decode.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    RED    = 2'd3
  } phase_e;

  localparam int unsigned DEF_GREEN_SECS  = 15;
  localparam int unsigned DEF_YELLOW_SECS = 3;
  localparam int unsigned DEF_RED_SECS    = 18;

  // Light vector is {red, yellow, green}; anything not one-hot decodes to IDLE.
  function automatic phase_e decode_lights(input logic [2:0] lights);
    case (lights)
      3'b001:  return GREEN;
      3'b010:  return YELLOW;
      3'b100:  return RED;
      default: return IDLE;
    endcase
  endfunction

  // Successor in the legal rotation; IDLE may be left towards any phase.
  function automatic phase_e next_legal(input phase_e p);
    case (p)
      GREEN:   return YELLOW;
      YELLOW:  return RED;
      RED:     return GREEN;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_timer.sv
// Per-phase seconds counter: saturating tick count, reload on phase change,
// and long/short duration compares against the selected phase's expectation.
module light_phase_timer
  import traffic_light_pkg::*;
#(
  parameter int unsigned pGREEN_SECS  = DEF_GREEN_SECS,
  parameter int unsigned pYELLOW_SECS = DEF_YELLOW_SECS,
  parameter int unsigned pRED_SECS    = DEF_RED_SECS,
  parameter int unsigned pTOL         = 0,
  parameter int unsigned pSECS_WIDTH  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   cnt_en,
  input  logic                   load,
  input  logic                   sec_tick,
  input  phase_e                 sel_phase,
  output logic [pSECS_WIDTH-1:0] elapsed,
  output logic                   long_err,
  output logic                   short_err
);

  logic [pSECS_WIDTH-1:0] elapsed_inc;
  logic [31:0]            exp_secs;
  logic [31:0]            hi_lim;
  logic [31:0]            lo_lim;

  always_comb begin
    exp_secs = '0;
    case (sel_phase)
      GREEN:   exp_secs = 32'(pGREEN_SECS);
      YELLOW:  exp_secs = 32'(pYELLOW_SECS);
      RED:     exp_secs = 32'(pRED_SECS);
      default: exp_secs = '0;
    endcase
    hi_lim = exp_secs + 32'(pTOL);
    lo_lim = (exp_secs > 32'(pTOL)) ? exp_secs - 32'(pTOL) : '0;
  end

  assign elapsed_inc = (&elapsed) ? elapsed : elapsed + 1'b1;

  // Long check looks at the value about to be stored so the flag lands with it.
  assign long_err  = sec_tick && (32'(elapsed_inc) > hi_lim);
  assign short_err = 32'(elapsed) < lo_lim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elapsed <= '0;
    end else if (en) begin
      if (load) begin
        elapsed <= {{(pSECS_WIDTH-1){1'b0}}, sec_tick};
      end else if (cnt_en && sec_tick) begin
        elapsed <= elapsed_inc;
      end
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: rebuilds phase/elapsed from observed lights and flags
// pattern, order and duration errors. Optional cycle counter: LIGHT_MON_CYCLE_CNT_EN.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int unsigned pGREEN_SECS  = DEF_GREEN_SECS,
  parameter int unsigned pYELLOW_SECS = DEF_YELLOW_SECS,
  parameter int unsigned pRED_SECS    = DEF_RED_SECS,
  parameter int unsigned pTOL         = 0,
  parameter int unsigned pSECS_WIDTH  = $clog2(pRED_SECS + pTOL + 2)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   sec_tick,
  input  logic                   green_light,
  input  logic                   yellow_light,
  input  logic                   red_light,
  input  logic                   clr_err,
  output logic [1:0]             phase,
  output logic [pSECS_WIDTH-1:0] elapsed,
  output logic                   phase_done,
  output logic [1:0]             last_phase,
  output logic [pSECS_WIDTH-1:0] last_secs,
  output logic                   err_onehot,
  output logic                   err_seq,
  output logic                   err_duration,
  output logic [15:0]            cycle_count
);

  phase_e                 phase_q, phase_d, obs_phase;
  logic                   partial_q, partial_d;
  logic                   done_d;
  logic [1:0]             last_phase_d;
  logic [pSECS_WIDTH-1:0] last_secs_d;
  logic                   legal, trans, seq_ok, check_dur;
  logic                   onehot_ev, seq_ev, dur_ev;
  logic                   long_err, short_err;

  assign phase = phase_q;

  light_phase_timer #(
    .pGREEN_SECS (pGREEN_SECS),
    .pYELLOW_SECS(pYELLOW_SECS),
    .pRED_SECS   (pRED_SECS),
    .pTOL        (pTOL),
    .pSECS_WIDTH (pSECS_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cnt_en   (legal && !trans),
    .load     (trans),
    .sec_tick (sec_tick),
    .sel_phase(phase_q),
    .elapsed  (elapsed),
    .long_err (long_err),
    .short_err(short_err)
  );

  always_comb begin
    obs_phase    = decode_lights({red_light, yellow_light, green_light});
    legal        = (obs_phase != IDLE);
    trans        = legal && (obs_phase != phase_q);
    seq_ok       = (phase_q == IDLE) || (obs_phase == next_legal(phase_q));
    check_dur    = !partial_q && (phase_q != IDLE);

    phase_d      = phase_q;
    done_d       = 1'b0;
    last_phase_d = last_phase;
    last_secs_d  = last_secs;
    partial_d    = partial_q;

    onehot_ev    = !legal;
    seq_ev       = trans && !seq_ok;
    dur_ev       = check_dur && (trans ? short_err : (legal && long_err));

    if (trans) begin
      phase_d = obs_phase;
      if (phase_q != IDLE) begin
        done_d       = 1'b1;
        last_phase_d = phase_q;
        last_secs_d  = elapsed;
        partial_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= IDLE;
      partial_q    <= 1'b1;
      phase_done   <= 1'b0;
      last_phase   <= '0;
      last_secs    <= '0;
      err_onehot   <= 1'b0;
      err_seq      <= 1'b0;
      err_duration <= 1'b0;
    end else if (en) begin
      phase_q      <= phase_d;
      partial_q    <= partial_d;
      phase_done   <= done_d;
      last_phase   <= last_phase_d;
      last_secs    <= last_secs_d;
      err_onehot   <= onehot_ev | (err_onehot & ~clr_err);
      err_seq      <= seq_ev | (err_seq & ~clr_err);
      err_duration <= dur_ev | (err_duration & ~clr_err);
    end
  end

`ifdef LIGHT_MON_CYCLE_CNT_EN
  // prog tracks how much of G->Y->R has been seen in legal order (0/1/2).
  logic [1:0]  prog_q, prog_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    prog_d = prog_q;
    cnt_d  = cnt_q;
    if (trans) begin
      if (seq_ev || phase_q == IDLE) begin
        prog_d = 2'd0;
      end else if (obs_phase == YELLOW) begin
        prog_d = 2'd1;
      end else if (obs_phase == RED) begin
        prog_d = (prog_q == 2'd1) ? 2'd2 : 2'd0;
      end else begin
        if (prog_q == 2'd2) cnt_d = cnt_q + 16'd1;
        prog_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_q <= 2'd0;
      cnt_q  <= '0;
    end else if (en) begin
      prog_q <= prog_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed table, test-plan
// sequences and randomized phases against a behavioural model.
module tb_traffic_light_monitor;

  localparam int G_S  = 15;
  localparam int Y_S  = 3;
  localparam int R_S  = 18;
  localparam int TOL  = 0;
  localparam int W    = $clog2(R_S + TOL + 2);
  localparam int MAXE = (1 << W) - 1;
`ifdef LIGHT_MON_CYCLE_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif
  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, sec_tick = 1'b0, clr_err = 1'b0;
  logic green_light = 1'b0, yellow_light = 1'b0, red_light = 1'b0;
  logic [1:0]   phase, last_phase;
  logic [W-1:0] elapsed, last_secs;
  logic         phase_done, err_onehot, err_seq, err_duration;
  logic [15:0]  cycle_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .pGREEN_SECS (G_S),
    .pYELLOW_SECS(Y_S),
    .pRED_SECS   (R_S),
    .pTOL        (TOL),
    .pSECS_WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sec_tick    (sec_tick),
    .green_light (green_light),
    .yellow_light(yellow_light),
    .red_light   (red_light),
    .clr_err     (clr_err),
    .phase       (phase),
    .elapsed     (elapsed),
    .phase_done  (phase_done),
    .last_phase  (last_phase),
    .last_secs   (last_secs),
    .err_onehot  (err_onehot),
    .err_seq     (err_seq),
    .err_duration(err_duration),
    .cycle_count (cycle_count)
  );

  typedef struct packed {
    logic       en;
    logic       tick;
    logic       clr;
    logic [2:0] lights;
  } in_t;

  typedef struct packed {
    in_t          in;
    logic [1:0]   ph;
    logic [W-1:0] el;
    logic         done;
    logic         eo;
    logic         es;
    logic         ed;
  } vec_t;

  function automatic in_t mk(input logic e, input logic t, input logic c, input logic [2:0] l);
    in_t r;
    r.en = e; r.tick = t; r.clr = c; r.lights = l;
    return r;
  endfunction

  function automatic vec_t vec(input in_t i, input int ph, input int el,
                               input logic d, input logic eo, input logic es, input logic ed);
    vec_t v;
    v.in = i; v.ph = 2'(ph); v.el = W'(el);
    v.done = d; v.eo = eo; v.es = es; v.ed = ed;
    return v;
  endfunction

  // Behavioural model: phases as integers 0..3, durations from a lookup table.
  int EXP[4] = '{0, G_S, Y_S, R_S};
  int NXT[4] = '{0, 2, 3, 1};
  int m_ph, m_el, m_last, m_lsecs, m_cnt;
  bit m_done, m_eo, m_es, m_ed, m_partial;
  int hist[$];

  function automatic int dec(input logic [2:0] v);
    if (v == LG) return 1;
    if (v == LY) return 2;
    if (v == LR) return 3;
    return -1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_last = 0; m_lsecs = 0; m_cnt = 0;
    m_done = 0; m_eo = 0; m_es = 0; m_ed = 0; m_partial = 1;
    hist.delete();
  endtask

  task automatic model_step(input in_t i);
    int p, lo;
    bit ev_o, ev_s, ev_d;
    if (i.en) begin
      ev_o = 0; ev_s = 0; ev_d = 0; m_done = 0;
      p = dec(i.lights);
      if (p < 0) begin
        ev_o = 1;
      end else if (p == m_ph) begin
        if (i.tick) begin
          if (m_el < MAXE) m_el = m_el + 1;
          if (!m_partial && m_el > EXP[m_ph] + TOL) ev_d = 1;
        end
      end else begin
        if (m_ph != 0) begin
          m_done = 1; m_last = m_ph; m_lsecs = m_el;
          lo = EXP[m_ph] - TOL;
          if (lo < 0) lo = 0;
          if (!m_partial && m_el < lo) ev_d = 1;
          if (p != NXT[m_ph]) ev_s = 1;
          m_partial = 0;
        end
        if (ev_s) hist.delete();
        if (CNT_ON != 0 && m_ph == 3 && p == 1 && hist.size() >= 3 &&
            hist[hist.size()-3] == 1 && hist[hist.size()-2] == 2 && hist[hist.size()-1] == 3)
          m_cnt = (m_cnt + 1) % 65536;
        hist.push_back(p);
        if (hist.size() > 3) void'(hist.pop_front());
        m_ph = p;
        m_el = i.tick ? 1 : 0;
      end
      m_eo = ev_o | (m_eo & !i.clr);
      m_es = ev_s | (m_es & !i.clr);
      m_ed = ev_d | (m_ed & !i.clr);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    bit ok;
    ok = (phase == 2'(m_ph)) && (elapsed == W'(m_el)) && (phase_done == m_done) &&
         (last_phase == 2'(m_last)) && (last_secs == W'(m_lsecs)) && (err_onehot == m_eo) &&
         (err_seq == m_es) && (err_duration == m_ed) && (cycle_count == 16'(m_cnt));
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL model t=%0t: got ph=%0d el=%0d done=%0d lp=%0d ls=%0d eo=%0d es=%0d ed=%0d cc=%0d want ph=%0d el=%0d done=%0d lp=%0d ls=%0d eo=%0d es=%0d ed=%0d cc=%0d",
               $time, phase, elapsed, phase_done, last_phase, last_secs, err_onehot, err_seq,
               err_duration, cycle_count, m_ph, m_el, m_done, m_last, m_lsecs, m_eo, m_es, m_ed, m_cnt);
    end
  endtask

  bit cap = 0;
  int done_ph[$];
  int done_secs[$];

  // Called at a negedge; drives, clocks, steps the model and compares.
  task automatic apply(input in_t i);
    en = i.en; sec_tick = i.tick; clr_err = i.clr;
    {red_light, yellow_light, green_light} = i.lights;
    @(posedge clk);
    model_step(i);
    @(negedge clk);
    check_model();
    if (cap && phase_done === 1'b1) begin
      done_ph.push_back(int'(last_phase));
      done_secs.push_back(int'(last_secs));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; sec_tick = 1'b0; clr_err = 1'b0;
    {red_light, yellow_light, green_light} = 3'b000;
    #1;
    check("reset_outputs", 32'({phase, elapsed, phase_done, last_phase, last_secs,
                                err_onehot, err_seq, err_duration}), 32'd0);
    check("reset_cycle_count", 32'(cycle_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_secs(input logic [2:0] l, input int n, input int period);
    for (int s = 0; s < n; s++)
      for (int c = 0; c < period; c++)
        apply(mk(1'b1, c == period - 1, 1'b0, l));
  endtask

  vec_t tbl[12];
  int exp_ph[4]   = '{1, 2, 3, 1};
  int exp_secs[4] = '{15, 3, 18, 15};

  initial begin
    tbl[0]  = vec(mk(1, 0, 0, LG),     1, 0, 0, 0, 0, 0);
    tbl[1]  = vec(mk(1, 1, 0, LG),     1, 1, 0, 0, 0, 0);
    tbl[2]  = vec(mk(1, 1, 0, LG),     1, 2, 0, 0, 0, 0);
    tbl[3]  = vec(mk(1, 0, 0, LY),     2, 0, 1, 0, 0, 0);
    tbl[4]  = vec(mk(1, 0, 0, 3'b011), 2, 0, 0, 1, 0, 0);
    tbl[5]  = vec(mk(1, 1, 0, LY),     2, 1, 0, 1, 0, 0);
    tbl[6]  = vec(mk(0, 1, 0, LR),     2, 1, 0, 1, 0, 0);
    tbl[7]  = vec(mk(1, 0, 1, LY),     2, 1, 0, 0, 0, 0);
    tbl[8]  = vec(mk(1, 1, 0, LG),     1, 1, 1, 0, 1, 1);
    tbl[9]  = vec(mk(1, 0, 1, LG),     1, 1, 0, 0, 0, 0);
    tbl[10] = vec(mk(1, 1, 0, LR),     3, 1, 1, 0, 1, 1);
    tbl[11] = vec(mk(1, 0, 0, 3'b000), 3, 1, 0, 1, 1, 1);

    @(negedge clk);
    do_reset();
    for (int k = 0; k < 12; k++) begin
      apply(tbl[k].in);
      check($sformatf("table[%0d]", k),
            32'({phase, elapsed, phase_done, err_onehot, err_seq, err_duration}),
            32'({tbl[k].ph, tbl[k].el, tbl[k].done, tbl[k].eo, tbl[k].es, tbl[k].ed}));
    end

    // Nominal cycle starting from a partial green.
    do_reset();
    cap = 1;
    run_secs(LG, 15, 100);
    run_secs(LY, 3, 100);
    run_secs(LR, 18, 100);
    run_secs(LG, 15, 100);
    check("nominal_errors", 32'({err_onehot, err_seq, err_duration}), 32'd0);
    check("nominal_cycle_count", 32'(cycle_count), 32'(CNT_ON));

    // Yellow overstays: flag rises with the 4th tick and stays.
    for (int s = 1; s <= 5; s++) begin
      for (int c = 0; c < 10; c++) apply(mk(1, c == 9, 0, LY));
      check($sformatf("yellow_hold_ed_%0d", s), 32'(err_duration), 32'(s >= 4));
      check($sformatf("yellow_hold_el_%0d", s), 32'(elapsed), 32'(s));
    end
    cap = 0;
    check("done_count", 32'(done_ph.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < done_ph.size()) begin
        check($sformatf("done_phase[%0d]", k), 32'(done_ph[k]), 32'(exp_ph[k]));
        check($sformatf("done_secs[%0d]", k), 32'(done_secs[k]), 32'(exp_secs[k]));
      end
    end
    apply(mk(1, 0, 0, LR));
    check("long_yellow_sticky", 32'(err_duration), 32'd1);
    check("long_yellow_secs", 32'(last_secs), 32'd5);
    apply(mk(1, 0, 1, LR));
    check("clr_err_duration", 32'(err_duration), 32'd0);

    // Green jumps straight to red.
    run_secs(LR, 18, 10);
    run_secs(LG, 3, 10);
    apply(mk(1, 0, 0, LR));
    check("jump_err_seq", 32'(err_seq), 32'd1);
    check("jump_phase", 32'(phase), 32'd3);
    check("jump_last_phase", 32'(last_phase), 32'd1);
    apply(mk(1, 0, 1, LR));

    // Glitch vector mid-green.
    run_secs(LG, 2, 10);
    apply(mk(1, 0, 0, 3'b011));
    check("glitch_err_onehot", 32'(err_onehot), 32'd1);
    check("glitch_phase", 32'(phase), 32'd1);
    check("glitch_elapsed", 32'(elapsed), 32'd2);

    // Freeze mid-red while ticks and lights keep moving.
    run_secs(LY, 3, 10);
    run_secs(LR, 5, 10);
    for (int c = 0; c < 300; c++) apply(mk(0, (c % 10) == 9, c[4], LG));
    check("freeze_phase", 32'(phase), 32'd3);
    check("freeze_elapsed", 32'(elapsed), 32'd5);
    apply(mk(1, 0, 0, LR));
    check("resume_no_tick", 32'(elapsed), 32'd5);
    apply(mk(1, 1, 0, LR));
    check("resume_tick", 32'(elapsed), 32'd6);

    // Reset mid-yellow with a sequence error pending.
    apply(mk(1, 0, 0, LY));
    check("pre_reset_err_seq", 32'(err_seq), 32'd1);
    run_secs(LY, 1, 10);
    do_reset();
    run_secs(LY, 1, 10);
    apply(mk(1, 0, 0, LR));
    check("partial_yellow_ed", 32'(err_duration), 32'd0);
    check("partial_yellow_es", 32'(err_seq), 32'd0);
    check("partial_yellow_done", 32'({phase_done, last_phase, last_secs}), 32'({1'b1, 2'd2, W'(1)}));

    // Randomized phases with jitter, glitches, freezes and clears.
    do_reset();
    for (int seg = 0; seg < 60; seg++) begin
      int p, secs;
      logic [2:0] pl;
      if (seg % 20 == 19) do_reset();
      if (m_ph == 0) p = $urandom_range(1, 3);
      else p = ($urandom_range(0, 9) < 8) ? NXT[m_ph] : $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) secs = $urandom_range(0, 35);
      else secs = EXP[p] - 1 + $urandom_range(0, 2);
      pl = (p == 1) ? LG : (p == 2) ? LY : LR;
      for (int s = 0; s < secs; s++) begin
        for (int c = 0; c < 4; c++) begin
          in_t ri;
          ri.en     = ($urandom_range(0, 9) != 0);
          ri.tick   = (c == 3);
          ri.clr    = ($urandom_range(0, 29) == 0);
          ri.lights = ($urandom_range(0, 39) == 0) ? 3'($urandom) : pl;
          apply(ri);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
